// File: rtl/fp_expand_stream.sv
// fp_expand_stream: lossless widening of signed Q-format samples through a
// 2-entry elastic buffer, with an output transfer counter and a peak |sample|
// monitor. Integer part is sign-extended, fraction is zero-padded.
module fp_expand_stream #(
    parameter int unsigned NB_XI  = 8,
    parameter int unsigned NBF_XI = 6,
    parameter int unsigned NB_XO  = 20,
    parameter int unsigned NBF_XO = 12,
    parameter int unsigned NB_CNT = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NB_XI-1:0]  i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [NB_XO-1:0]  o_data,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic              i_clear,
    output logic [NB_CNT-1:0] o_count,
    output logic [NB_XI-1:0]  o_peak
);

    // Fraction padding width; the sign-extension width is implied by NB_XO.
    localparam int unsigned PAD = NBF_XO - NBF_XI;

    // Reject formats that cannot hold the input exactly.
    if (((int'(NB_XO) - int'(NBF_XO)) < (int'(NB_XI) - int'(NBF_XI))) ||
        (int'(NBF_XO) < int'(NBF_XI))) begin : g_bad_format
        $fatal(1, "fp_expand_stream: output format narrower than input format");
    end

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e              occ_q, occ_d;
    logic [NB_XO-1:0]  head_q, head_d;
    logic [NB_XO-1:0]  tail_q, tail_d;
    logic [NB_CNT-1:0] count_q, count_d;
    logic [NB_XI-1:0]  peak_q, peak_d;

    logic              push_c;
    logic              pop_c;
    logic [NB_XO-1:0]  wide_c;
    logic [NB_XI-1:0]  abs_c;

    // Handshake qualifiers; ready depends on registered occupancy only.
    always_comb begin
        push_c = i_valid && (occ_q != OCC_FULL);
        pop_c  = (occ_q != OCC_EMPTY) && i_ready;
    end

    // Widening and unsigned magnitude of the incoming sample.
    always_comb begin
        wide_c = NB_XO'($signed(i_data)) << PAD;
        abs_c  = i_data[NB_XI-1] ? (~i_data + NB_XI'(1)) : i_data;
    end

    // Buffer occupancy FSM and entry updates; new words queue behind the head.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push_c) begin
                    head_d = wide_c;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push_c && pop_c) begin
                    head_d = wide_c;
                end else if (push_c) begin
                    tail_d = wide_c;
                    occ_d  = OCC_FULL;
                end else if (pop_c) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop_c) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    // Transfer counter and peak monitor; clear wins over same-cycle updates.
    always_comb begin
        count_d = count_q;
        peak_d  = peak_q;
        if (i_clear) begin
            count_d = '0;
            peak_d  = '0;
        end else begin
            if (pop_c) begin
                count_d = count_q + NB_CNT'(1);
            end
            if (push_c && (abs_c > peak_q)) begin
                peak_d = abs_c;
            end
        end
    end

    // State registers; reset discards buffered words immediately.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            occ_q   <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            peak_q  <= '0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            peak_q  <= peak_d;
        end
    end

    // Output mapping from registered state.
    always_comb begin
        o_valid = (occ_q != OCC_EMPTY);
        o_ready = (occ_q != OCC_FULL);
        o_data  = head_q;
        o_count = count_q;
        o_peak  = peak_q;
    end

endmodule

// File: tb/tb_fp_expand_stream.sv
// Directed bench for fp_expand_stream: widening, backpressure, push/pop
// concurrency, peak/clear, counter wrap and mid-stream reset.
module tb_fp_expand_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_ready;
    logic        i_clear;
    logic        o_ready;
    logic [19:0] o_data;
    logic        o_valid;
    logic [15:0] o_count;
    logic [7:0]  o_peak;

    logic [7:0]  w_data;
    logic        w_valid;
    logic        w_ready;
    logic        w_clear;
    logic        w_o_ready;
    logic [19:0] w_o_data;
    logic        w_o_valid;
    logic [3:0]  w_count;
    logic [7:0]  w_peak;

    int total = 0;
    int bad   = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    fp_expand_stream dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .i_clear (i_clear),
        .o_count (o_count),
        .o_peak  (o_peak)
    );

    fp_expand_stream #(.NB_CNT(4)) dut_wrap (
        .i_clock (clk),
        .i_reset (rst),
        .i_data  (w_data),
        .i_valid (w_valid),
        .o_ready (w_o_ready),
        .o_data  (w_o_data),
        .o_valid (w_o_valid),
        .i_ready (w_ready),
        .i_clear (w_clear),
        .o_count (w_count),
        .o_peak  (w_peak)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Q(2,6) -> Q(8,12): six sign copies, sample, six zero fraction bits.
    function automatic logic [19:0] widen(input logic [7:0] d);
        return {{6{d[7]}}, d, 6'b000000};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream n words base, base+1, ... with i_ready low in cycles [slo, shi].
    task automatic stream(input int n, input logic [7:0] base, input int slo, input int shi);
        logic [7:0] q[$];
        int   sent = 0;
        int   got  = 0;
        int   cyc  = 0;
        int   occm = 0;
        logic push;
        logic pop;
        while ((sent < n || got < n) && cyc < 200) begin
            i_valid = (sent < n);
            i_data  = 8'(int'(base) + sent);
            i_ready = !(cyc >= slo && cyc <= shi);
            chk("stream_ready", 32'(o_ready), 32'(occm != 2));
            chk("stream_valid", 32'(o_valid), 32'(occm != 0));
            push = (sent < n) && (occm != 2);
            pop  = (occm != 0) && i_ready;
            if (pop) begin
                chk("stream_order", 32'(o_data), 32'(widen(q[0])));
                void'(q.pop_front());
                got++;
                exp_count++;
            end
            if (push) begin
                q.push_back(8'(int'(base) + sent));
                sent++;
            end
            occm = occm + int'(push) - int'(pop);
            step();
            cyc++;
        end
        i_valid = 1'b0;
        chk("stream_len", 32'(got), 32'(n));
        chk("stream_count", 32'(o_count), 32'(exp_count));
    endtask

    logic [7:0]  wv [5] = '{8'h40, 8'h80, 8'h7F, 8'h01, 8'hFF};
    logic [19:0] we [5] = '{20'h01000, 20'hFE000, 20'h01FC0, 20'h00040, 20'hFFFC0};
    logic [7:0]  pv [4] = '{8'h10, 8'hC0, 8'h80, 8'h20};
    logic [7:0]  pe [4] = '{8'd16, 8'd64, 8'd128, 8'd128};

    initial begin
        rst = 1'b1; i_data = '0; i_valid = 1'b0; i_ready = 1'b0; i_clear = 1'b0;
        w_data = '0; w_valid = 1'b0; w_ready = 1'b1; w_clear = 1'b0;
        step(); step();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_peak", 32'(o_peak), 32'd0);
        chk("rst_wcount", 32'(w_count), 32'd0);
        rst = 1'b0;
        step();

        // Widening, one cycle after acceptance.
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_data = wv[k]; i_valid = 1'b1;
            step();
            i_valid = 1'b0;
            chk("widen_valid", 32'(o_valid), 32'd1);
            chk("widen_data", 32'(o_data), 32'(we[k]));
        end
        step();
        chk("widen_drain", 32'(o_valid), 32'd0);
        chk("widen_count", 32'(o_count), 32'd5);
        chk("widen_peak", 32'(o_peak), 32'd128);

        i_clear = 1'b1; step(); i_clear = 1'b0;
        exp_count = 0;
        chk("clear_count", 32'(o_count), 32'd0);
        chk("clear_peak", 32'(o_peak), 32'd0);

        // Backpressure, then sustained simultaneous push/pop at occ=1.
        stream(8, 8'h01, 2, 5);
        chk("bp_count8", 32'(o_count), 32'd8);
        stream(11, 8'h30, -1, -1);

        // Peak tracking and clear with a concurrent transfer.
        i_clear = 1'b1; step(); i_clear = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_data = pv[k]; i_valid = 1'b1;
            step();
            chk("peak", 32'(o_peak), 32'(pe[k]));
        end
        i_data = 8'h30; i_valid = 1'b1; i_clear = 1'b1;
        step();
        i_valid = 1'b0; i_clear = 1'b0;
        chk("clrx_count", 32'(o_count), 32'd0);
        chk("clrx_peak", 32'(o_peak), 32'd0);
        chk("clrx_valid", 32'(o_valid), 32'd1);
        chk("clrx_data", 32'(o_data), 32'h00C00);
        step();
        chk("clrx_count1", 32'(o_count), 32'd1);
        chk("clrx_peak0", 32'(o_peak), 32'd0);
        chk("clrx_drain", 32'(o_valid), 32'd0);

        // Counter wrap on the NB_CNT=4 instance.
        for (int k = 0; k < 17; k++) begin
            w_data = 8'(k); w_valid = 1'b1;
            step();
            if (k == 15) chk("wrap_15", 32'(w_count), 32'd15);
        end
        w_valid = 1'b0;
        step();
        chk("wrap_17", 32'(w_count), 32'd1);

        // Fill the buffer, then reset asynchronously mid-cycle.
        i_ready = 1'b0;
        i_data = 8'h11; i_valid = 1'b1; step();
        i_data = 8'h22; step();
        i_valid = 1'b0;
        chk("full_ready", 32'(o_ready), 32'd0);
        chk("full_valid", 32'(o_valid), 32'd1);
        chk("full_head", 32'(o_data), 32'(widen(8'h11)));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_ready", 32'(o_ready), 32'd1);
        chk("arst_count", 32'(o_count), 32'd0);
        chk("arst_peak", 32'(o_peak), 32'd0);
        chk("arst_data", 32'(o_data), 32'd0);
        step(); step();
        rst = 1'b0;
        exp_count = 0;
        step();
        stream(3, 8'h05, -1, -1);
        chk("resume_peak", 32'(o_peak), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
